// File: rtl/wb_stage_p_if.sv
// wb_stage_p_if: write-back stage bus, master = upstream pipeline, slave = stage.
interface wb_stage_p_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          valid_in;
   logic          flush_in;
   logic          stall_in;
   logic          RW;
   logic [AW-1:0] DA;
   logic [1:0]    MD;
   logic          VxorN;
   logic [DW-1:0] F;
   logic [DW-1:0] PC_1;
   logic [DW-1:0] Data;
   logic          Data_valid;
   logic [DW-1:0] BUS_D;
   logic          RW_out;
   logic [AW-1:0] DA_out;
   logic [1:0]    MD_out;
   logic          valid_out;
   logic          stall_out;
   logic [31:0]   RETIRED;
   modport master (
      output valid_in, flush_in, stall_in, RW, DA, MD, VxorN, F, PC_1, Data, Data_valid,
      input  BUS_D, RW_out, DA_out, MD_out, valid_out, stall_out, RETIRED
   );
   modport slave (
      input  valid_in, flush_in, stall_in, RW, DA, MD, VxorN, F, PC_1, Data, Data_valid,
      output BUS_D, RW_out, DA_out, MD_out, valid_out, stall_out, RETIRED
   );
endinterface

// File: rtl/wb_stage_p.sv
// wb_stage_p: write-back stage with registered result select, stall/flush,
// late-load wait state and retired-instruction counter.
module wb_stage_p #(
   parameter int DW          = 32,
   parameter int AW          = 5,
   parameter bit ZERO_REG_EN = 1'b1
) (
   input logic         CLOCK,
   input logic         RESET,
   wb_stage_p_if.slave bus
);
   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;
   logic [0:0]    state;
   logic          valid_r, rw_r, vx_r;
   logic [AW-1:0] da_r;
   logic [1:0]    md_r;
   logic [DW-1:0] f_r, pc_r, data_r;
   logic [31:0]   retired;
   logic          adv, commit, live;
   assign adv    = (state == RUN) && !bus.stall_in;
   assign commit = valid_r && adv;
   assign live   = bus.valid_in && !bus.flush_in;
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state   <= RUN;
         valid_r <= 1'b0;
         rw_r    <= 1'b0;
         vx_r    <= 1'b0;
         da_r    <= '0;
         md_r    <= '0;
         f_r     <= '0;
         pc_r    <= '0;
         data_r  <= '0;
         retired <= '0;
      end else begin
         if (adv) begin
            valid_r <= live;
            rw_r    <= bus.RW;
            da_r    <= bus.DA;
            md_r    <= bus.MD;
            vx_r    <= bus.VxorN;
            f_r     <= bus.F;
            pc_r    <= bus.PC_1;
            if (bus.Data_valid) data_r <= bus.Data;
            // a load whose data has not arrived parks the stage until it does
            state   <= (live && bus.MD == 2'd1 && !bus.Data_valid) ? WAIT : RUN;
         end else if (state == WAIT && bus.Data_valid) begin
            data_r <= bus.Data;
            state  <= RUN;
         end
         if (commit) retired <= retired + 32'd1;
      end
   end
   assign bus.BUS_D     = md_r[1] ? (md_r[0] ? pc_r : {{(DW-1){1'b0}}, vx_r})
                                  : (md_r[0] ? data_r : f_r);
   assign bus.RW_out    = commit && rw_r && !(ZERO_REG_EN && da_r == '0);
   assign bus.DA_out    = da_r;
   assign bus.MD_out    = md_r;
   assign bus.valid_out = valid_r;
   assign bus.stall_out = !adv;
   assign bus.RETIRED   = retired;
endmodule
